cgol_gen_engine: RTL and testbench



---
 rtl/cgol_gen_engine.sv | 160 ++++++++++++++++
 tb/tb_cgol_gen_engine.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgol_gen_engine.sv
// Game of Life generation engine: double-buffered board, one row per clock,
// start/busy/done handshake with generation counter and still-life flag.
module cgol_gen_engine #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 8,
  parameter int unsigned GEN_W  = 8,
  parameter int unsigned AW     = ($clog2(HEIGHT) > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic             ph1,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_row,
  input  logic             start,
  input  logic             wrap,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_row,
  output logic             busy,
  output logic             done,
  output logic             stable,
  output logic [GEN_W-1:0] gen_count
);

  localparam logic [AW-1:0] LastRow = AW'(HEIGHT - 1);

  typedef enum logic {StIdle, StStep} state_e;

  state_e             r_state, w_state_d;
  logic [WIDTH-1:0]   r_bank [2][HEIGHT];
  logic               r_act;
  logic [AW-1:0]      r_row;
  logic               r_wrap;
  logic               r_same;
  logic               r_done;
  logic               r_stable;
  logic [GEN_W-1:0]   r_gen;
  logic [WIDTH-1:0]   r_rd;

  logic               w_accept;
  logic               w_commit;
  logic [WIDTH-1:0]   w_up, w_cur, w_dn, w_next;
  logic [WIDTH+1:0]   w_up_x, w_cur_x, w_dn_x;
  logic [3:0]         w_sum [WIDTH];
  logic               w_row_eq;

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    w_commit  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A simultaneous load wins over start.
        if (start && !load_en) begin
          w_accept  = 1'b1;
          w_state_d = StStep;
        end
      end
      StStep: begin
        if (r_row == LastRow) begin
          w_commit  = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_cur = r_bank[r_act][r_row];
    if (r_row == '0) begin
      w_up = r_wrap ? r_bank[r_act][LastRow] : '0;
    end else begin
      w_up = r_bank[r_act][r_row - 1'b1];
    end
    if (r_row == LastRow) begin
      w_dn = r_wrap ? r_bank[r_act][0] : '0;
    end else begin
      w_dn = r_bank[r_act][r_row + 1'b1];
    end
  end

  // Rows padded with one column each side: bit 0 is left of column 0.
  assign w_up_x  = {r_wrap & w_up[0],  w_up,  r_wrap & w_up[WIDTH-1]};
  assign w_cur_x = {r_wrap & w_cur[0], w_cur, r_wrap & w_cur[WIDTH-1]};
  assign w_dn_x  = {r_wrap & w_dn[0],  w_dn,  r_wrap & w_dn[WIDTH-1]};

  always_comb begin
    w_sum  = '{default: '0};
    w_next = '0;
    for (int c = 0; c < WIDTH; c++) begin
      w_sum[c] = 4'(w_up_x[c]) + 4'(w_up_x[c+1]) + 4'(w_up_x[c+2])
               + 4'(w_cur_x[c]) + 4'(w_cur_x[c+2])
               + 4'(w_dn_x[c]) + 4'(w_dn_x[c+1]) + 4'(w_dn_x[c+2]);
      w_next[c] = (w_sum[c] == 4'd3) | (w_cur[c] & (w_sum[c] == 4'd2));
    end
  end

  assign w_row_eq = (w_next == w_cur);

  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge ph1 or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int h = 0; h < HEIGHT; h++) begin
          r_bank[b][h] <= '0;
        end
      end
      r_act    <= 1'b0;
      r_row    <= '0;
      r_wrap   <= 1'b0;
      r_same   <= 1'b0;
      r_done   <= 1'b0;
      r_stable <= 1'b0;
      r_gen    <= '0;
      r_rd     <= '0;
    end else begin
      r_done <= w_commit;
      if (32'(rd_addr) < HEIGHT) begin
        r_rd <= r_bank[r_act][rd_addr];
      end else begin
        r_rd <= '0;
      end
      if (r_state == StIdle) begin
        if (load_en && (32'(load_addr) < HEIGHT)) begin
          r_bank[r_act][load_addr] <= load_row;
          r_stable                 <= 1'b0;
        end
        if (w_accept) begin
          r_wrap <= wrap;
          r_row  <= '0;
          r_same <= 1'b1;
        end
      end else begin
        r_bank[~r_act][r_row] <= w_next;
        r_same                <= r_same & w_row_eq;
        r_row                 <= r_row + 1'b1;
        if (w_commit) begin
          r_act    <= ~r_act;
          r_gen    <= r_gen + 1'b1;
          r_stable <= r_same & w_row_eq;
          r_row    <= '0;
        end
      end
    end
  end

  assign rd_row    = r_rd;
  assign busy      = (r_state == StStep);
  assign done      = r_done;
  assign stable    = r_stable;
  assign gen_count = r_gen;

endmodule

// File: tb/tb_cgol_gen_engine.sv
// Self-checking bench for cgol_gen_engine: vector table, hand sequences and
// random boards against a neighbour-counting reference model.
module tb_cgol_gen_engine;

  localparam int W = 8;
  localparam int H = 8;

  typedef logic [H-1:0][W-1:0] board_t;
  typedef struct {
    board_t pat;
    logic   w;
    board_t exp;
    logic   st;
  } vec_t;

  logic         ph1 = 1'b0;
  logic         reset_n;
  logic         load_en;
  logic [2:0]   load_addr;
  logic [W-1:0] load_row;
  logic         start;
  logic         wrap;
  logic [2:0]   rd_addr;
  logic [W-1:0] rd_row;
  logic         busy;
  logic         done;
  logic         stable;
  logic [7:0]   gen_count;

  int     n_cmp = 0;
  int     n_err = 0;
  int     exp_gen = 0;
  board_t mb;
  vec_t   vecs [6];

  cgol_gen_engine dut (
    .ph1       (ph1),
    .reset_n   (reset_n),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_row  (load_row),
    .start     (start),
    .wrap      (wrap),
    .rd_addr   (rd_addr),
    .rd_row    (rd_row),
    .busy      (busy),
    .done      (done),
    .stable    (stable),
    .gen_count (gen_count)
  );

  always #5 ph1 = ~ph1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  function automatic board_t model_next(input board_t b, input logic w);
    board_t nb;
    int n, rr, cc;
    nb = '0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (w) begin
              rr = (rr + H) % H;
              cc = (cc + W) % W;
            end
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < H && cc >= 0 && cc < W) begin
              if (b[rr][cc]) n++;
            end
          end
        end
        nb[r][c] = (n == 3) || (b[r][c] && n == 2);
      end
    end
    return nb;
  endfunction

  task automatic do_reset();
    @(negedge ph1);
    reset_n = 1'b0;
    @(negedge ph1);
    @(negedge ph1);
    reset_n = 1'b1;
    exp_gen = 0;
    mb = '0;
  endtask

  task automatic load_board(input board_t b);
    for (int h = 0; h < H; h++) begin
      @(negedge ph1);
      load_en   = 1'b1;
      load_addr = 3'(h);
      load_row  = b[h];
    end
    @(negedge ph1);
    load_en = 1'b0;
    mb = b;
  endtask

  task automatic do_step(input logic w);
    int n;
    @(negedge ph1);
    start = 1'b1;
    wrap  = w;
    @(negedge ph1);
    start = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge ph1);
    end
    exp_gen++;
    check("busy_len", n, H);
    check("done_high", done, 1);
    check("busy_in_done", busy, 0);
    check("gen_count", gen_count, exp_gen % 256);
    @(negedge ph1);
    check("done_pulse_end", done, 0);
  endtask

  task automatic check_board(input string nm, input board_t b);
    for (int h = 0; h < H; h++) begin
      @(negedge ph1);
      rd_addr = 3'(h);
      @(negedge ph1);
      check(nm, rd_row, b[h]);
    end
  endtask

  initial begin
    board_t b, prev;
    logic   w;
    int     n, ndone, cyc, t1, t2;

    reset_n = 1'b1; load_en = 1'b0; load_addr = '0; load_row = '0;
    start = 1'b0; wrap = 1'b0; rd_addr = '0;
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stable", stable, 0);
    check("rst_gen", gen_count, 0);
    check_board("rst_rows", '0);

    // Vector table: pattern, edge mode, expected next board, expected stable
    vecs[0].pat = '0; vecs[0].pat[3] = 8'h1C; vecs[0].w = 1'b1;
    vecs[0].exp = '0; vecs[0].exp[2] = 8'h08; vecs[0].exp[3] = 8'h08; vecs[0].exp[4] = 8'h08;
    vecs[0].st = 1'b0;
    vecs[1].pat = '0; vecs[1].pat[3] = 8'h18; vecs[1].pat[4] = 8'h18; vecs[1].w = 1'b1;
    vecs[1].exp = vecs[1].pat; vecs[1].st = 1'b1;
    vecs[2].pat = '0; vecs[2].pat[3] = 8'h83; vecs[2].w = 1'b1;
    vecs[2].exp = '0; vecs[2].exp[2] = 8'h01; vecs[2].exp[3] = 8'h01; vecs[2].exp[4] = 8'h01;
    vecs[2].st = 1'b0;
    vecs[3].pat = vecs[2].pat; vecs[3].w = 1'b0; vecs[3].exp = '0; vecs[3].st = 1'b0;
    vecs[4].pat = '1; vecs[4].w = 1'b1; vecs[4].exp = '0; vecs[4].st = 1'b0;
    vecs[5].pat = '0; vecs[5].w = 1'b0; vecs[5].exp = '0; vecs[5].st = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load_board(vecs[i].pat);
      check($sformatf("vec%0d_stable_after_load", i), stable, 0);
      do_step(vecs[i].w);
      check($sformatf("vec%0d_stable", i), stable, vecs[i].st);
      check_board($sformatf("vec%0d_row", i), vecs[i].exp);
    end

    // Blinker period 2
    b = '0; b[3] = 8'h1C;
    load_board(b);
    do_step(1'b1);
    do_step(1'b1);
    check_board("blinker_restore", b);

    // Still life then a load clears stable
    b = '0; b[3] = 8'h18; b[4] = 8'h18;
    load_board(b);
    do_step(1'b1);
    check("block_stable", stable, 1);
    @(negedge ph1);
    load_en = 1'b1; load_addr = 3'd0; load_row = 8'h00;
    @(negedge ph1);
    load_en = 1'b0;
    check("load_clears_stable", stable, 0);

    // start pulse and load during busy are both ignored
    b = '0; b[1] = 8'h0E; b[6] = 8'h60;
    load_board(b);
    @(negedge ph1);
    start = 1'b1; wrap = 1'b1;
    @(negedge ph1);
    start = 1'b0;
    @(negedge ph1);
    start = 1'b1;
    @(negedge ph1);
    start = 1'b0; load_en = 1'b1; load_addr = 3'd0; load_row = 8'hFF;
    @(negedge ph1);
    load_en = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      n++;
      @(negedge ph1);
    end
    exp_gen++;
    check("busy_start_done_seen", done, 1);
    check("busy_start_gen", gen_count, exp_gen % 256);
    @(negedge ph1);
    @(negedge ph1);
    check("busy_start_no_requeue", busy, 0);
    check("busy_start_gen_hold", gen_count, exp_gen % 256);
    mb = model_next(mb, 1'b1);
    check_board("busy_load_ignored", mb);

    // load_en and start together: load wins, no step
    @(negedge ph1);
    load_en = 1'b1; start = 1'b1; load_addr = 3'd5; load_row = 8'h5A;
    @(negedge ph1);
    load_en = 1'b0; start = 1'b0;
    check("load_start_busy", busy, 0);
    @(negedge ph1);
    check("load_start_busy2", busy, 0);
    check("load_start_gen", gen_count, exp_gen % 256);
    mb[5] = 8'h5A;
    check_board("load_start_rows", mb);

    // Random boards against the reference model
    for (int i = 0; i < 10; i++) begin
      for (int h = 0; h < H; h++) b[h] = 8'($urandom);
      w = 1'($urandom_range(0, 1));
      load_board(b);
      for (int s = 0; s < 2; s++) begin
        prev = mb;
        do_step(w);
        mb = model_next(prev, w);
        check($sformatf("rand%0d_stable", i), stable, (mb == prev) ? 1 : 0);
        check_board($sformatf("rand%0d_s%0d_row", i, s), mb);
      end
    end

    // Reset mid-step
    b = '1; b[2] = 8'h3C;
    load_board(b);
    @(negedge ph1);
    start = 1'b1; wrap = 1'b1;
    @(negedge ph1);
    start = 1'b0;
    @(negedge ph1);
    @(negedge ph1);
    check("midstep_busy_before_reset", busy, 1);
    do_reset();
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_stable", stable, 0);
    check("midrst_gen", gen_count, 0);
    check("midrst_rd_row", rd_row, 0);
    check_board("midrst_rows", '0);
    do_step(1'b1);
    check_board("midrst_shadow_clear", '0);

    // Back-to-back steps and counter wrap
    do_reset();
    @(negedge ph1);
    start = 1'b1; wrap = 1'b1;
    ndone = 0; cyc = 0; t1 = 0; t2 = 0;
    while (ndone < 255 && cyc < 5000) begin
      @(negedge ph1);
      cyc++;
      if (done) begin
        ndone++;
        if (ndone == 1) t1 = cyc;
        if (ndone == 2) t2 = cyc;
      end
    end
    check("b2b_done_count", ndone, 255);
    check("b2b_period", t2 - t1, H + 1);
    check("gen_at_255", gen_count, 255);
    @(negedge ph1);
    start = 1'b0;
    check("b2b_accept_in_done", busy, 1);
    n = 0;
    while (!done && n < 50) begin
      n++;
      @(negedge ph1);
    end
    check("gen_wrap_done", done, 1);
    check("gen_wrap_zero", gen_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
